// File: rtl/banked_shared_mem.sv
// Word-interleaved banked shared memory serving one warp request at a time.
// Bank conflicts are replayed over several passes (one per cycle); lanes that
// hit the same word in a bank share a single access (load broadcast, store merge).
module banked_shared_mem #(
   parameter int NUM_BANKS  = 32,
   parameter int THREADS    = 32,
   parameter int BANK_DEPTH = 128,
   parameter int WARP_ID_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [WARP_ID_W-1:0]  req_warp_id,
   input  logic [THREADS-1:0]    req_mask,
   input  logic [THREADS*32-1:0] req_addr,
   input  logic [THREADS*32-1:0] req_wdata,
   input  logic [THREADS*4-1:0]  req_be,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_write,
   output logic [WARP_ID_W-1:0]  resp_warp_id,
   output logic [THREADS-1:0]    resp_mask,
   output logic [THREADS*32-1:0] resp_rdata,
   output logic [5:0]            resp_passes,
   output logic [31:0]           access_count,
   output logic [31:0]           conflict_cycles
);

   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = $clog2(BANK_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // Request context and bookkeeping
   logic [1:0]             state_q, state_d;
   logic                   write_q, write_d;
   logic [WARP_ID_W-1:0]   warp_id_q, warp_id_d;
   logic [THREADS-1:0]     mask_q, mask_d;
   logic [THREADS-1:0]     pending_q, pending_d;
   logic [5:0]             passes_q, passes_d;
   logic [THREADS*32-1:0]  wdata_q, wdata_d;
   logic [THREADS*4-1:0]   be_q, be_d;
   logic [THREADS*32-1:0]  rdata_q, rdata_d;
   logic [31:0]            access_count_q, access_count_d;
   logic [31:0]            conflict_q, conflict_d;
   logic [BANK_W-1:0]      lane_bank_q [THREADS];
   logic [BANK_W-1:0]      lane_bank_d [THREADS];
   logic [ROW_W-1:0]       lane_row_q  [THREADS];
   logic [ROW_W-1:0]       lane_row_d  [THREADS];

   // Per-pass arbitration results
   logic [ROW_W-1:0]       bank_row   [NUM_BANKS];
   logic [31:0]            bank_wdata [NUM_BANKS];
   logic [3:0]             bank_wbe   [NUM_BANKS];
   logic [THREADS-1:0]     served;
   logic [31:0]            rd_word    [THREADS];

   // Storage: NUM_BANKS independent banks of 32-bit words
   logic [31:0]            mem [NUM_BANKS][BANK_DEPTH];

   // Offset bits and address bits above the array size are intentionally ignored
   logic                   unused_addr;
   assign unused_addr = ^req_addr;

   // Leader row per bank: the lowest-index pending lane mapped to that bank
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_row[b] = '0;
         for (int l = THREADS - 1; l >= 0; l--) begin
            if (pending_q[l] && (lane_bank_q[l] == BANK_W'(b))) begin
               bank_row[b] = lane_row_q[l];
            end
         end
      end
   end

   // Lanes served this pass and merged store data per bank (highest lane wins per byte)
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_wdata[b] = '0;
         bank_wbe[b]   = '0;
      end
      for (int l = 0; l < THREADS; l++) begin
         served[l]  = pending_q[l] && (lane_row_q[l] == bank_row[lane_bank_q[l]]);
         rd_word[l] = mem[lane_bank_q[l]][lane_row_q[l]];
         if (served[l] && write_q) begin
            for (int k = 0; k < 4; k++) begin
               if (be_q[l*4 + k]) begin
                  bank_wdata[lane_bank_q[l]][k*8 +: 8] = wdata_q[l*32 + k*8 +: 8];
                  bank_wbe[lane_bank_q[l]][k]          = 1'b1;
               end
            end
         end
      end
   end

   // Next-state logic for the IDLE -> SERVE -> RESP request flow
   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      warp_id_d      = warp_id_q;
      mask_d         = mask_q;
      pending_d      = pending_q;
      passes_d       = passes_q;
      wdata_d        = wdata_q;
      be_d           = be_q;
      rdata_d        = rdata_q;
      access_count_d = access_count_q;
      conflict_d     = conflict_q;
      lane_bank_d    = lane_bank_q;
      lane_row_d     = lane_row_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d        = req_write;
               warp_id_d      = req_warp_id;
               mask_d         = req_mask;
               pending_d      = req_mask;
               passes_d       = '0;
               wdata_d        = req_wdata;
               be_d           = req_be;
               rdata_d        = '0;
               access_count_d = access_count_q + 32'd1;
               for (int l = 0; l < THREADS; l++) begin
                  lane_bank_d[l] = req_addr[l*32 + 2 +: BANK_W];
                  lane_row_d[l]  = req_addr[l*32 + 2 + BANK_W +: ROW_W];
               end
               state_d = (req_mask == '0) ? ST_RESP : ST_SERVE;
            end
         end
         ST_SERVE: begin
            passes_d  = passes_q + 6'd1;
            pending_d = pending_q & ~served;
            for (int l = 0; l < THREADS; l++) begin
               if (served[l] && !write_q) begin
                  rdata_d[l*32 +: 32] = rd_word[l];
               end
            end
            if (pending_d == '0) begin
               // passes_q is the final pass count minus one
               conflict_d = conflict_q + 32'(passes_q);
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and context registers, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         write_q        <= 1'b0;
         warp_id_q      <= '0;
         mask_q         <= '0;
         pending_q      <= '0;
         passes_q       <= '0;
         wdata_q        <= '0;
         be_q           <= '0;
         rdata_q        <= '0;
         access_count_q <= '0;
         conflict_q     <= '0;
         for (int l = 0; l < THREADS; l++) begin
            lane_bank_q[l] <= '0;
            lane_row_q[l]  <= '0;
         end
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         warp_id_q      <= warp_id_d;
         mask_q         <= mask_d;
         pending_q      <= pending_d;
         passes_q       <= passes_d;
         wdata_q        <= wdata_d;
         be_q           <= be_d;
         rdata_q        <= rdata_d;
         access_count_q <= access_count_d;
         conflict_q     <= conflict_d;
         lane_bank_q    <= lane_bank_d;
         lane_row_q     <= lane_row_d;
      end
   end

   // Byte-enabled bank writes for the current store pass
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; contents survive rst_n so completed store passes persist.
      if ((state_q == ST_SERVE) && write_q) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < 4; k++) begin
               if (bank_wbe[b][k]) begin
                  mem[b][bank_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
               end
            end
         end
      end
   end

   assign req_ready       = (state_q == ST_IDLE);
   assign resp_valid      = (state_q == ST_RESP);
   assign resp_write      = write_q;
   assign resp_warp_id    = warp_id_q;
   assign resp_mask       = mask_q;
   assign resp_rdata      = rdata_q;
   assign resp_passes     = passes_q;
   assign access_count    = access_count_q;
   assign conflict_cycles = conflict_q;

endmodule
